// File: rtl/demux_1_8_deser_if.sv
// Handshake/data bundle between the serial source, the 1:8 deserializer and its word consumer.
interface demux_1_8_deser_if;
  logic       i_start;
  logic       i_f;
  logic       i_f_valid;
  logic [2:0] o_sel_code;
  logic [7:0] o_code;
  logic       o_code_valid;
  logic       i_code_ready;
  logic       o_busy;
  logic       o_overrun;

  modport slave (
    input  i_start, i_f, i_f_valid, i_code_ready,
    output o_sel_code, o_code, o_code_valid, o_busy, o_overrun
  );

  modport master (
    output i_start, i_f, i_f_valid, i_code_ready,
    input  o_sel_code, o_code, o_code_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/demux_1_8_deser.sv
// 1:8 serial-to-parallel deserializer: collects eight slot bits into a staging word and
// hands complete frames to a valid/ready consumer, flagging frames dropped on back-pressure.
module demux_1_8_deser #(
  parameter int LSB_FIRST = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  demux_1_8_deser_if.slave      bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] stage_q, stage_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic [7:0] frame_s;
  logic       complete_s;
  logic       ovr_evt_s;

  // Staging holds bits in slot order; bit order of the delivered word is applied only at load.
  function automatic logic [7:0] map_slots(input logic [7:0] slots);
    logic [7:0] word;
    word = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (LSB_FIRST != 0) begin
        word[k] = slots[k];
      end else begin
        word[7 - k] = slots[k];
      end
    end
    return word;
  endfunction

  // Next-state, slot capture and output-word handshake logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    stage_d    = stage_q;
    code_d     = code_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    complete_s = 1'b0;
    ovr_evt_s  = 1'b0;
    frame_s    = stage_q;
    frame_s[sel_q] = bus.i_f;

    if (bus.i_start) begin
      state_d    = FILL;
      stage_d    = 8'h00;
      stage_d[0] = bus.i_f_valid & bus.i_f;
      sel_d      = bus.i_f_valid ? 3'd1 : 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_d = 3'd0;
        end
        FILL: begin
          if (bus.i_f_valid) begin
            stage_d    = frame_s;
            sel_d      = sel_q + 3'd1;
            complete_s = (sel_q == 3'd7);
          end else begin
            stage_d = stage_q;
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = 3'd0;
        end
      endcase
    end

    if (valid_q && bus.i_code_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A held, unaccepted word wins over a newly completed frame.
    if (complete_s) begin
      if (!valid_q || bus.i_code_ready) begin
        code_d  = map_slots(frame_s);
        valid_d = 1'b1;
      end else begin
        ovr_evt_s = 1'b1;
      end
    end else begin
      code_d = code_q;
    end

    if (ovr_evt_s) begin
      ovr_d = 1'b1;
    end else if (bus.i_start) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      stage_q <= 8'h00;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      stage_q <= stage_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_sel_code   = sel_q;
  assign bus.o_code       = code_q;
  assign bus.o_code_valid = valid_q;
  assign bus.o_busy       = (state_q == FILL);
  assign bus.o_overrun    = ovr_q;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Self-checking bench: two deserializers (LSB_FIRST=1 and 0) on shared stimulus, compared
// every cycle against a queue-based frame model, plus fixed expected words for known streams.
module tb_demux_1_8_deser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_1_8_deser_if bus_lsb ();
  demux_1_8_deser_if bus_msb ();

  assign bus_msb.i_start      = bus_lsb.i_start;
  assign bus_msb.i_f          = bus_lsb.i_f;
  assign bus_msb.i_f_valid    = bus_lsb.i_f_valid;
  assign bus_msb.i_code_ready = bus_lsb.i_code_ready;

  demux_1_8_deser #(.LSB_FIRST(1)) u_lsb (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_lsb));
  demux_1_8_deser #(.LSB_FIRST(0)) u_msb (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_msb));

  // Reference model: a frame is just the list of bits received since the last sync.
  bit         m_in_frame;
  bit         m_bits[$];
  logic [7:0] m_code_lsb;
  logic [7:0] m_code_msb;
  bit         m_valid;
  bit         m_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_bits.delete();
    m_code_lsb = 8'h00;
    m_code_msb = 8'h00;
    m_valid    = 1'b0;
    m_ovr      = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit fv, input bit f, input bit rdy);
    bit load = 1'b0;
    bit drop = 1'b0;
    bit nv;
    logic [7:0] w_lsb = 8'h00;
    logic [7:0] w_msb = 8'h00;
    if (st) begin
      m_in_frame = 1'b1;
      m_bits.delete();
      if (fv) m_bits.push_back(f);
    end else if (m_in_frame && fv) begin
      m_bits.push_back(f);
      if (m_bits.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          w_lsb[k]     = m_bits[k];
          w_msb[7 - k] = m_bits[k];
        end
        m_bits.delete();
        if (!m_valid || rdy) load = 1'b1;
        else drop = 1'b1;
      end
    end
    nv = m_valid;
    if (m_valid && rdy) nv = 1'b0;
    if (load) begin
      nv = 1'b1;
      m_code_lsb = w_lsb;
      m_code_msb = w_msb;
    end
    m_valid = nv;
    if (drop) m_ovr = 1'b1;
    else if (st) m_ovr = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("sel_code", bus_lsb.o_sel_code, m_bits.size());
    check_eq("busy", bus_lsb.o_busy, m_in_frame);
    check_eq("code_valid", bus_lsb.o_code_valid, m_valid);
    check_eq("overrun", bus_lsb.o_overrun, m_ovr);
    check_eq("code_lsb", bus_lsb.o_code, m_code_lsb);
    check_eq("code_msb", bus_msb.o_code, m_code_msb);
    check_eq("valid_msb", bus_msb.o_code_valid, m_valid);
  endtask

  task automatic cycle(input bit st, input bit fv, input bit f, input bit rdy);
    bus_lsb.i_start      = st;
    bus_lsb.i_f_valid    = fv;
    bus_lsb.i_f          = f;
    bus_lsb.i_code_ready = rdy;
    model_step(st, fv, f, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Sends slot k = slots[k]; optional random idle gaps before each bit.
  task automatic send_frame(input logic [7:0] slots, input bit with_start,
                            input bit rdy_fill, input bit rdy_last, input int max_gap);
    logic [7:0] s;
    s = slots;
    for (int k = 0; k < 8; k++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap)) cycle(1'b0, 1'b0, 1'b0, rdy_fill);
      cycle(with_start && (k == 0), 1'b1, s[k], (k == 7) ? rdy_last : rdy_fill);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_lsb.i_start      = 1'b0;
    bus_lsb.i_f          = 1'b0;
    bus_lsb.i_f_valid    = 1'b0;
    bus_lsb.i_code_ready = 1'b0;
    model_reset();
    #12;
    compare_all();
    check_eq("rst_code", bus_lsb.o_code, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Valid bits in IDLE are ignored
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("idle_sel", bus_lsb.o_sel_code, 3'd0);

    // Stream 1,0,1,1,0,0,1,0
    send_frame(8'b0100_1101, 1'b1, 1'b1, 1'b1, 0);
    check_eq("s29_code_lsb", bus_lsb.o_code, 8'h4D);
    check_eq("s29_code_msb", bus_msb.o_code, 8'hB2);
    check_eq("s29_valid", bus_lsb.o_code_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s29_valid_1cyc", bus_lsb.o_code_valid, 1'b0);

    // Overrun: A5 held, 3C dropped, sync clears the flag
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    check_eq("s31_first", bus_lsb.o_code, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    check_eq("s31_held", bus_lsb.o_code, 8'hA5);
    check_eq("s31_ovr", bus_lsb.o_overrun, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("s31_ovr_clr", bus_lsb.o_overrun, 1'b0);
    check_eq("s31_valid_kept", bus_lsb.o_code_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames, second accepted on its completion cycle
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 0);
    check_eq("s32_first", bus_lsb.o_code, 8'h0F);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 0);
    check_eq("s32_second", bus_lsb.o_code, 8'hF0);
    check_eq("s32_valid", bus_lsb.o_code_valid, 1'b1);
    check_eq("s32_ovr", bus_lsb.o_overrun, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync after 5 bits, then 81 with gaps
    for (int k = 0; k < 5; k++) cycle(k == 0, 1'b1, 1'($urandom_range(1)), 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 3);
    check_eq("s33_code", bus_lsb.o_code, 8'h81);

    // Async reset after 4 bits, then unsynced bits ignored
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("s34_code", bus_lsb.o_code, 8'h00);
    check_eq("s34_busy", bus_lsb.o_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("s34_sel", bus_lsb.o_sel_code, 3'd0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom % 16) == 0, ($urandom % 4) != 0, 1'($urandom_range(1)),
            1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1_8_deser.md
DEMUX_1_8_DESER -- requirements
Module: demux_1_8_deser

Interface
REQ-001 Parameter LSB_FIRST, default 1; when 1, slot k maps to o_code[k]; when 0, slot k maps to o_code[7-k].
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  frame-sync pulse; forces slot index to 0.
REQ-006 i_f  input  1  serial data bit (one slot per valid cycle).
REQ-007 i_f_valid  input  1  i_f carries a slot bit this cycle.
REQ-008 o_sel_code  output  3  current slot index; the transmitter's 8:1 select follows it.
REQ-009 o_code  output  8  assembled parallel word.
REQ-010 o_code_valid  output  1  o_code holds an unconsumed word.
REQ-011 i_code_ready  input  1  consumer accepts o_code when high with o_code_valid.
REQ-012 o_busy  output  1  high in state FILL.
REQ-013 o_overrun  output  1  sticky; a completed frame was dropped.

Function
REQ-014 The FSM SHALL have two states, IDLE and FILL; reset enters IDLE.
REQ-015 IDLE: i_f_valid ignored; o_sel_code held at 0; i_start moves to FILL on the next edge.
REQ-016 i_start with i_f_valid in the same cycle (any state) SHALL capture i_f into slot 0 and set o_sel_code to 1.
REQ-017 FILL: each i_f_valid cycle SHALL write i_f into staging bit for slot o_sel_code and increment o_sel_code modulo 8.
REQ-018 Cycles with i_f_valid low SHALL leave staging and o_sel_code unchanged (gaps allowed, no timeout).
REQ-019 Frame completion = i_f_valid with o_sel_code==7; o_sel_code wraps to 0 and FILL continues (back-to-back frames, no dead cycle).
REQ-020 On completion, if o_code_valid is low, or high with i_code_ready high that cycle, the full 8-bit frame (including the current bit) SHALL load into o_code and o_code_valid SHALL be 1 on the next cycle (latency 1 clock from the 8th bit).
REQ-021 On completion with o_code_valid high and i_code_ready low, the frame SHALL be discarded, o_code unchanged, o_overrun set to 1.
REQ-022 Handshake: o_code_valid && i_code_ready clears o_code_valid next cycle unless a new frame loads in the same cycle (REQ-020); o_code holds its last value after consumption.
REQ-023 o_code_valid SHALL NOT drop without handshake; o_code SHALL NOT change while o_code_valid is high and unaccepted.
REQ-024 i_start mid-frame in FILL SHALL discard the partial frame, set o_sel_code to 0 (or 1 per REQ-016), and leave o_code/o_code_valid untouched.
REQ-025 i_start SHALL clear o_overrun; an overrun event in the same cycle as i_start takes priority (o_overrun=1).
REQ-026 Partial-frame staging bits are never visible on o_code; only complete frames load.

Reset
REQ-027 While i_rst_n=0 (asynchronously): state IDLE, o_sel_code=0, o_code=8'h00, o_code_valid=0, o_busy=0, o_overrun=0, staging=8'h00.
REQ-028 Reset asserted mid-frame SHALL discard the frame; operation resumes only after a new i_start.

Verification
REQ-029 LSB_FIRST=1, i_start then 8 valid bits 1,0,1,1,0,0,1,0 with i_code_ready=1 -> o_code=8'h4D, o_code_valid high exactly 1 cycle, 1 clock after 8th bit.
REQ-030 Same stream with LSB_FIRST=0 -> o_code=8'hB2.
REQ-031 Frame 8'hA5 unconsumed (i_code_ready=0), second frame 8'h3C completes -> o_code stays 8'hA5, o_overrun=1; i_start clears o_overrun.
REQ-032 Back-to-back 8'h0F then 8'hF0 with i_code_ready=1 on the completion cycle of frame 2 -> o_code 8'h0F then 8'hF0, o_code_valid continuously high, no overrun.
REQ-033 i_start after 5 bits, then full frame 8'h81 -> o_code=8'h81; valid gaps between bits do not alter result.
REQ-034 i_rst_n low after 4 bits -> all outputs at REQ-027 values immediately; bits without i_start after release ignored, o_sel_code stays 0.
